// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer with a 2-entry FIFO per output lane.
// Define DEMUX_AUTO_SEL_EN to replace in_sel with an internal round-robin lane pointer.
module demux_1_4_stream #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data
);

  logic [1:0] dest;
  logic [3:0] full;
  logic       accept;

`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] ptr_reg;
  logic [1:0] sel_unused;

  assign sel_unused = in_sel;

  // Pointer advances only on an accepted word; a full target lane stalls input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= 2'd0;
    end else if (accept) begin
      ptr_reg <= ptr_reg + 2'd1;
    end
  end

  assign dest = ptr_reg;
`else
  assign dest = in_sel;
`endif

  // Readiness looks only at the target lane, never at in_valid.
  assign in_ready = rst_n && !full[dest];
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [1:0]   count_reg;
      logic [1:0]   count_next;
      logic [W-1:0] head_reg;
      logic [W-1:0] tail_reg;
      logic         push;
      logic         pop;

      assign push = accept && (dest == 2'(gi));
      assign pop  = out_valid[gi] && out_ready[gi];

      assign out_valid[gi]        = (count_reg != 2'd0);
      assign full[gi]             = (count_reg == 2'd2);
      assign out_data[gi*W +: W]  = out_valid[gi] ? head_reg : '0;

      always_comb begin
        count_next = count_reg;
        case ({push, pop})
          2'b10:   count_next = count_reg + 2'd1;
          2'b01:   count_next = count_reg - 2'd1;
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count_reg <= 2'd0;
          head_reg  <= '0;
          tail_reg  <= '0;
        end else begin
          count_reg <= count_next;
          // Head takes the second entry on a pop from full, or the incoming
          // word when it lands in an empty (or just-emptied) lane.
          if (pop && full[gi]) begin
            head_reg <= tail_reg;
          end else if (push && (count_reg == 2'd0 || (count_reg == 2'd1 && pop))) begin
            head_reg <= in_data;
          end else if (push) begin
            tail_reg <= in_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_demux_1_4_stream;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;

  demux_1_4_stream #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per lane plus the round-robin pointer.
  logic [W-1:0] mq [4][$];
  int           m_ptr = 0;

  typedef struct {
    logic           rst;
    logic           vld;
    logic [1:0]     sel;
    logic [W-1:0]   dat;
    logic [3:0]     ordy;
    logic           exp_rdy;
    logic [3:0]     exp_ov;
    logic [4*W-1:0] exp_od;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_dest();
`ifdef DEMUX_AUTO_SEL_EN
    return 2'(m_ptr);
`else
    return in_sel;
`endif
  endfunction

  function automatic logic m_ready();
    if (!rst_n) return 1'b0;
    return mq[m_dest()].size() != 2;
  endfunction

  task automatic model_check();
    logic [3:0]     ov;
    logic [4*W-1:0] od;
    ov = '0;
    od = '0;
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0) begin
        ov[k] = 1'b1;
        od[k*W +: W] = mq[k][0];
      end
    end
    check("model_in_ready", 16'(in_ready), 16'(m_ready()));
    check("model_out_valid", 16'(out_valid), 16'(ov));
    check("model_out_data", 16'(out_data), 16'(od));
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] d, input logic [3:0] ordy);
    rst_n = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    #1;
    model_check();
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic         acc;
    logic [1:0]   d;
    logic [W-1:0] w;
    logic         r;
    logic [3:0]   ordy;
    acc = in_valid && m_ready();
    d = m_dest();
    w = in_data;
    r = rst_n;
    ordy = out_ready;
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (ordy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
      if (acc) begin
        mq[d].push_back(w);
        m_ptr = (m_ptr + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  logic [W-1:0] xv;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 2'd0, 4'ha, 4'h0, 1'b0, 4'b0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 2'd0, 4'ha, 4'h0, 1'b1, 4'b0000, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 2'd1, 4'hb, 4'h0, 1'b1, 4'b0001, 16'h000a};
    tbl[3] = '{1'b1, 1'b1, 2'd2, 4'hc, 4'h0, 1'b1, 4'b0011, 16'h00ba};
    tbl[4] = '{1'b1, 1'b1, 2'd3, 4'hd, 4'h0, 1'b1, 4'b0111, 16'h0cba};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'b1111, 16'hdcba};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'hf, 1'b1, 4'b1111, 16'hdcba};
    tbl[7] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'b0000, 16'h0000};

    // Bring the DUT out of its unknown power-up state before any comparison.
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
    #1;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].ordy);
      check($sformatf("tbl%0d_in_ready", i), 16'(in_ready), 16'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_out_valid", i), 16'(out_valid), 16'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_out_data", i), 16'(out_data), 16'(tbl[i].exp_od));
      tick();
    end

`ifndef DEMUX_AUTO_SEL_EN
    // Lane 1 fills, third word stalls even with out_ready[1] high, order kept.
    drive(1, 1, 2'd1, 4'd7, 4'h0);  check("l1_rdy_w1", 16'(in_ready), 16'd1); tick();
    drive(1, 1, 2'd1, 4'd10, 4'h0); check("l1_rdy_w2", 16'(in_ready), 16'd1); tick();
    drive(1, 1, 2'd1, 4'd3, 4'h0);  check("l1_rdy_full", 16'(in_ready), 16'd0);
    check("l1_head_7", 16'(out_data[4 +: 4]), 16'd7); tick();
    drive(1, 1, 2'd1, 4'd3, 4'h2);  check("l1_no_pushthru", 16'(in_ready), 16'd0);
    check("l1_pop_7", 16'(out_data[4 +: 4]), 16'd7); tick();
    drive(1, 1, 2'd1, 4'd3, 4'h2);  check("l1_rdy_after_pop", 16'(in_ready), 16'd1);
    check("l1_pop_10", 16'(out_data[4 +: 4]), 16'd10); tick();
    drive(1, 0, 2'd1, 4'd0, 4'h0);  check("l1_head_3", 16'(out_data[4 +: 4]), 16'd3);
    check("l1_valid", 16'(out_valid), 16'b0010); tick();
    drive(1, 0, 2'd0, 4'd0, 4'h2); tick();

    // Lane 2 full and stalled while lane 0 keeps flowing.
    drive(1, 1, 2'd2, 4'd1, 4'h0); tick();
    drive(1, 1, 2'd2, 4'd2, 4'h0); tick();
    drive(1, 1, 2'd2, 4'd9, 4'h0); check("l2_stalled", 16'(in_ready), 16'd0); tick();
    drive(1, 1, 2'd0, 4'd5, 4'h0); check("l0_ready", 16'(in_ready), 16'd1); tick();
    drive(1, 0, 2'd0, 4'd0, 4'h0);
    check("l0_got_5", 16'(out_data[0 +: 4]), 16'd5);
    check("l2_head_kept", 16'(out_data[8 +: 4]), 16'd1);
    tick();

    // Unknown payload bits pass through unchanged.
    xv = 'x;
    drive(1, 1, 2'd3, xv, 4'h0); tick();
    drive(1, 0, 2'd0, 4'd0, 4'h0);
    check("l3_x_data", 16'(out_data[12 +: 4]), 16'(xv));
    check("l3_x_valid", 16'(out_valid[3]), 16'd1);
    tick();

    // Reset mid-operation discards everything and blocks the input.
    drive(0, 1, 2'd1, 4'd6, 4'h0); check("rst_in_ready", 16'(in_ready), 16'd0); tick();
    drive(1, 0, 2'd1, 4'd0, 4'h0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", 16'(out_data), 16'd0);
    check("rst_release_ready", 16'(in_ready), 16'd1);
    tick();
`else
    // Round-robin: 1..5 land in lanes 0,1,2,3,0 regardless of in_sel.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 2'd0, 4'(i), 4'h0); tick();
    end
    drive(1, 0, 2'd0, 4'd0, 4'h0);
    check("rr_valid", 16'(out_valid), 16'b1111);
    check("rr_data", 16'(out_data), 16'h4321);
    tick();
    drive(1, 0, 2'd0, 4'd0, 4'h1); tick();
    drive(1, 0, 2'd0, 4'd0, 4'h0); check("rr_lane0_second", 16'(out_data[0 +: 4]), 16'd5); tick();
    drive(0, 0, 2'd0, 4'd0, 4'h0); tick();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 63) != 0), 1'($urandom), 2'($urandom), W'($urandom),
            4'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
